pong_vga_render: RTL
====================

// Module: pong_vga_render
// PURPOSE
//  Downstream consumer of the Nios system's position outputs (bx/by/p1x/p1y/p2x/p2y).
//  Generates 640x480@60 VGA timing and draws the ball, both paddles and a centre line.
//  Drives the Nios busy input so that software updates positions only during vertical blanking.
//  Positions are shadow-latched once per frame, so a frame never shows a torn update.
// PARAMETERS
//  PIX_DIV   2   clk cycles per pixel (50 MHz clk -> 25 MHz pixel tick)
//  BALL_SZ   8   ball square side, pixels
//  PAD_W     8   paddle width, pixels
//  PAD_H     64  paddle height, pixels
//  FG_RGB    12'hFFF  foreground colour {r,g,b}
//  BG_RGB    12'h000  background colour
// PORTS
//  clk_clk       in   1   system clock
//  reset_reset   in   1   synchronous, active-high reset
//  bx_in         in   10  ball x (top-left), pixels
//  by_in         in   10  ball y (top-left)
//  p1x_in        in   10  paddle 1 x (top-left)
//  p1y_in        in   10  paddle 1 y
//  p2x_in        in   10  paddle 2 x
//  p2y_in        in   10  paddle 2 y
//  busy_out      out  1   to Nios busy_export; 1 = drawing, do not update positions
//  frame_tick    out  1   one clk pulse at the start of each frame (shadow latch instant)
//  vga_hs        out  1   horizontal sync, active low
//  vga_vs        out  1   vertical sync, active low
//  vga_blank_n   out  1   1 = active video
//  vga_r/g/b     out  4   colour components (each 4 bits)
// BEHAVIOUR
//  - Pixel tick: divider counter 0..PIX_DIV-1. tick=1 when the divider = PIX_DIV-1.
//    All raster state advances only on tick.
//  - hcnt 0..799, wraps to 0. vcnt increments when hcnt wraps; vcnt 0..524, wraps to 0.
//  - Horizontal: active 0-639, front porch 640-655, sync 656-751, back porch 752-799.
//  - Vertical:   active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
//  - Shadow latch:
//    - On the tick where hcnt=799 and vcnt=524 (the last pixel of the frame), copy all six *_in into shadow registers.
//    - frame_tick pulses high for that same clk cycle.
//  - busy_out is registered: busy_out = (vcnt<480) after each tick.
//    It deasserts the cycle after vcnt reaches 480 and reasserts when vcnt wraps to 0.
//  - Hit test uses the shadow registers and the current (hcnt,vcnt). Comparisons are 11-bit, so obj+size cannot overflow.
//    - ball:   bx <= h < bx+BALL_SZ and by <= v < by+BALL_SZ
//    - paddle: px <= h < px+PAD_W  and py <= v < py+PAD_H
//    - centre: h in {319,320} and v[3]=0 (dashed line)
//  - Colour: FG_RGB if any hit AND active, else BG_RGB if active, else 12'h000.
//  - Latency: one pixel tick.
//    - hs, vs, blank_n and rgb are all registered together on the tick, so they stay mutually aligned.
//    - Outputs hold their value between ticks.
//  - Objects partially off-screen (x > 639 - size) are clipped naturally. No wrap to the left edge.
//  - Reset values:
//    - counters and divider = 0; shadows = 0
//    - vga_hs = 1, vga_vs = 1, vga_blank_n = 0, rgb = 0
//    - busy_out = 0, frame_tick = 0
//  - Reset mid-frame: everything returns to reset values on the next clk edge.
//    The raster restarts at (0,0) and the first post-reset frame uses zero shadows until the first latch.
//  - Input changes while busy_out = 1 have no visible effect until the next latch.
// TESTING
//  1. Reset, run 2 frames:
//     - period = 800*525*PIX_DIV clk cycles
//     - hs low exactly 96 ticks starting at h=656; vs low for v=490-491.
//  2. bx=100, by=200, paddles at 700,700, then frame_tick:
//     - next frame FG only at h 100-107, v 200-207 (plus the centre line).
//  3. p1x=16, p1y=208: the FG block spans h 16-23, v 208-271. Pixel (24,208) must be BG.
//  4. Change bx at v=100 of the current frame:
//     - the current frame still draws the old bx
//     - the next frame draws the new bx.
//  5. busy_out falls on the tick after v goes 479->480 and rises again at v=0.
//     frame_tick count equals the frame count.
//  6. Assert reset at h=300, v=250:
//     - next cycle hs=vs=1, blank_n=0, rgb=0
//     - the raster resumes from (0,0).

Source files
------------

// File: rtl/pong_vga_render.sv
// pong_vga_render: VGA raster drawing ball, paddles and centre line from positions shadowed once per frame
module pong_vga_render #(
  parameter int PIX_DIV = 2,
  parameter int BALL_SZ = 8,
  parameter int PAD_W = 8,
  parameter int PAD_H = 64,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000,
  parameter int H_ACT = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACT = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [9:0] bx_in,
  input  logic [9:0] by_in,
  input  logic [9:0] p1x_in,
  input  logic [9:0] p1y_in,
  input  logic [9:0] p2x_in,
  input  logic [9:0] p2y_in,
  output logic       busy_out,
  output logic       frame_tick,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  logic [DW-1:0] div;
  logic [9:0] hcnt, vcnt, h_nx, v_nx, sbx, sby, sp1x, sp1y, sp2x, sp2y;
  logic [11:0] rgb;
  logic tick, h_end, last, active, hit;
  function automatic logic span(input logic [9:0] p, input logic [9:0] lo, input int sz);
    return {1'b0, p} >= {1'b0, lo} && {1'b0, p} < {1'b0, lo} + 11'(sz);
  endfunction
  always_comb begin
    tick = div == DW'(PIX_DIV - 1);
    h_end = hcnt == 10'(H_TOT - 1);
    last = h_end && vcnt == 10'(V_TOT - 1);
    h_nx = h_end ? '0 : hcnt + 10'd1;
    v_nx = h_end ? (last ? '0 : vcnt + 10'd1) : vcnt;
    active = hcnt < 10'(H_ACT) && vcnt < 10'(V_ACT);
    hit = (span(hcnt, sbx, BALL_SZ) && span(vcnt, sby, BALL_SZ)) ||
          (span(hcnt, sp1x, PAD_W) && span(vcnt, sp1y, PAD_H)) ||
          (span(hcnt, sp2x, PAD_W) && span(vcnt, sp2y, PAD_H)) ||
          ((hcnt == 10'(H_ACT / 2 - 1) || hcnt == 10'(H_ACT / 2)) && !vcnt[3]);
    frame_tick = tick && last && !reset_reset;
  end
  assign {vga_r, vga_g, vga_b} = rgb;
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div <= '0;
      hcnt <= '0;
      vcnt <= '0;
      {sbx, sby, sp1x, sp1y, sp2x, sp2y} <= '0;
      busy_out <= 1'b0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_blank_n <= 1'b0;
      rgb <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        hcnt <= h_nx;
        vcnt <= v_nx;
        busy_out <= v_nx < 10'(V_ACT);
        vga_hs <= !(hcnt >= 10'(H_ACT + H_FP) && hcnt < 10'(H_ACT + H_FP + H_SYNC));
        vga_vs <= !(vcnt >= 10'(V_ACT + V_FP) && vcnt < 10'(V_ACT + V_FP + V_SYNC));
        vga_blank_n <= active;
        rgb <= active ? (hit ? FG_RGB : BG_RGB) : 12'h000;
        if (last) {sbx, sby, sp1x, sp1y, sp2x, sp2y} <= {bx_in, by_in, p1x_in, p1y_in, p2x_in, p2y_in};
      end
    end
  end
endmodule
